// File: rtl/denormalizer_16_if.sv
// Handshake bundle for denormalizer_16: upstream operand side (i_valid/o_ready/i_in/i_fill/i_count)
// and downstream result side (o_valid/i_ready/o_r/o_sticky).
interface denormalizer_16_if #(
    parameter int unsigned N = 16
);
    localparam int unsigned CW = $clog2(N) + 1;

    logic          i_valid;
    logic          o_ready;
    logic [N:0]    i_in;
    logic          i_fill;
    logic [CW-1:0] i_count;
    logic          o_valid;
    logic          i_ready;
    logic [N:0]    o_r;
    logic          o_sticky;

    modport slave (
        input  i_valid, i_in, i_fill, i_count, i_ready,
        output o_ready, o_valid, o_r, o_sticky
    );

    modport master (
        output i_valid, i_in, i_fill, i_count, i_ready,
        input  o_ready, o_valid, o_r, o_sticky
    );
endinterface

// File: rtl/denormalizer_16.sv
// Pipelined right shifter with fill bit and sticky collection; one register stage per shift
// weight (16, 8, 4, 2, 1), valid/ready handshake on both sides.
module denormalizer_16 #(
    parameter int unsigned N = 16
) (
    input logic             i_clk,
    input logic             i_rst,
    denormalizer_16_if.slave bus
);
    localparam int unsigned W      = N + 1;
    localparam int unsigned CW     = $clog2(N) + 1;
    localparam int unsigned Stages = CW;

    logic [Stages-1:0] valid_q, valid_d;
    logic [Stages-1:0] fill_q, fill_d;
    logic [Stages-1:0] sticky_q, sticky_d;
    logic [W-1:0]      data_q  [Stages];
    logic [W-1:0]      data_d  [Stages];
    logic [CW-1:0]     count_q [Stages];
    logic [CW-1:0]     count_d [Stages];
    logic [Stages-1:0] load;

    logic [Stages-1:0] src_valid, src_fill, src_sticky;
    logic [W-1:0]      src_data  [Stages];
    logic [CW-1:0]     src_count [Stages];

    // A stage may load unless it and every stage after it are full while the output is stalled.
    always_comb begin : ready_chain
        logic tail_full;
        tail_full = 1'b1;
        for (int i = Stages - 1; i >= 0; i--) begin
            tail_full = tail_full & valid_q[i];
            load[i]   = ~tail_full | bus.i_ready;
        end
    end

    always_comb begin : stage_src
        src_valid[0]  = bus.i_valid;
        src_data[0]   = bus.i_in;
        src_fill[0]   = bus.i_fill;
        src_count[0]  = bus.i_count;
        src_sticky[0] = 1'b0;
        for (int i = 1; i < Stages; i++) begin
            src_valid[i]  = valid_q[i-1];
            src_data[i]   = data_q[i-1];
            src_fill[i]   = fill_q[i-1];
            src_count[i]  = count_q[i-1];
            src_sticky[i] = sticky_q[i-1];
        end
    end

    always_comb begin : stage_next
        logic [2*W-1:0] ext;
        logic [W-1:0]   mask;
        logic [W-1:0]   nd;
        logic [CW-1:0]  nc;
        logic           ns;
        int unsigned    sh;
        for (int i = 0; i < Stages; i++) begin
            sh   = 32'd1 << (Stages - 1 - i);
            ext  = {{W{src_fill[i]}}, src_data[i]} >> sh;
            mask = (W'(1) << sh) - W'(1);
            nd   = src_data[i];
            nc   = src_count[i];
            ns   = src_sticky[i];
            if (i == 0 && src_count[i] >= CW'(W)) begin
                // Whole word shifted out; clearing the count keeps later stages from touching sticky.
                nd = {W{src_fill[i]}};
                nc = '0;
                ns = |src_data[i];
            end else if (src_count[i][Stages-1-i]) begin
                nd = ext[W-1:0];
                ns = src_sticky[i] | (|(src_data[i] & mask));
            end

            valid_d[i]  = valid_q[i];
            data_d[i]   = data_q[i];
            fill_d[i]   = fill_q[i];
            count_d[i]  = count_q[i];
            sticky_d[i] = sticky_q[i];
            if (load[i]) begin
                valid_d[i] = src_valid[i];
                if (src_valid[i]) begin
                    data_d[i]   = nd;
                    fill_d[i]   = src_fill[i];
                    count_d[i]  = nc;
                    sticky_d[i] = ns;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= '0;
            fill_q   <= '0;
            sticky_q <= '0;
            for (int i = 0; i < Stages; i++) begin
                data_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            fill_q   <= fill_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < Stages; i++) begin
                data_q[i]  <= data_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    assign bus.o_ready  = load[0];
    assign bus.o_valid  = valid_q[Stages-1];
    assign bus.o_r      = data_q[Stages-1];
    assign bus.o_sticky = sticky_q[Stages-1];
endmodule

// File: tb/tb_denormalizer_16.sv
// Scoreboard bench for denormalizer_16: expected {sticky, r} queued on input acceptance and
// compared in order as results leave the pipeline.
module tb_denormalizer_16;
    localparam int unsigned N = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [17:0] exp_q [$];

    denormalizer_16_if #(.N(N)) bus ();
    denormalizer_16 #(.N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Direct reference: {sticky, r}
    function automatic logic [17:0] model(input logic [16:0] d, input logic f, input logic [4:0] c);
        logic [33:0] ext;
        logic [16:0] r;
        logic        s;
        if (c >= 5'd17) begin
            r = {17{f}};
            s = |d;
        end else begin
            ext = {{17{f}}, d} >> c;
            r   = ext[16:0];
            s   = 1'b0;
            for (int b = 0; b < 17; b++) if (b < int'(c)) s = s | d[b];
        end
        return {s, r};
    endfunction

    function automatic logic [16:0] rand_word();
        logic [16:0] x;
        int unsigned run;
        x   = 17'($urandom);
        run = $urandom_range(0, 17);
        for (int b = 0; b < 17; b++) if (b >= 17 - int'(run)) x[b] = x[16];
        return x;
    endfunction

    // Leading-run length of the normalizer (bits equal to the MSB), 0..17
    function automatic logic [4:0] run_len(input logic [16:0] x);
        logic [4:0] n;
        logic       go;
        n  = '0;
        go = 1'b1;
        for (int b = 16; b >= 0; b--) begin
            if (go && x[b] == x[16]) n = n + 5'd1;
            else go = 1'b0;
        end
        return n;
    endfunction

    // Drive one cycle at the negedge and report what the next posedge will transfer.
    task automatic tick(input logic v, input logic [16:0] d, input logic f, input logic [4:0] c,
                        input logic rdy, output logic acc, output logic ofire,
                        output logic [16:0] r, output logic s);
        @(negedge clk);
        bus.i_valid = v;
        bus.i_in    = d;
        bus.i_fill  = f;
        bus.i_count = c;
        bus.i_ready = rdy;
        #1;
        acc   = v & bus.o_ready;
        ofire = bus.o_valid & rdy;
        r     = bus.o_r;
        s     = bus.o_sticky;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_in    = '0;
        bus.i_fill  = 1'b0;
        bus.i_count = '0;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0) begin
            failures++; $display("FAIL reset_o_valid got=%b want=0", bus.o_valid);
        end
        checks++;
        if (bus.o_r !== 17'h0) begin
            failures++; $display("FAIL reset_o_r got=%h want=00000", bus.o_r);
        end
        checks++;
        if (bus.o_sticky !== 1'b0) begin
            failures++; $display("FAIL reset_o_sticky got=%b want=0", bus.o_sticky);
        end
        checks++;
        if (bus.o_ready !== 1'b1) begin
            failures++; $display("FAIL reset_o_ready got=%b want=1", bus.o_ready);
        end
    endtask

    task automatic test_basic();
        logic a, of, s;
        logic [16:0] r;
        logic [17:0] e;
        int acc_step = -1;
        int out_step = -1;
        for (int k = 0; k < 20 && out_step < 0; k++) begin
            tick(k == 0, 17'h10000, 1'b0, 5'd3, 1'b1, a, of, r, s);
            if (a) begin
                acc_step = k;
                exp_q.push_back({1'b0, 17'h02000});
            end
            if (of) begin
                out_step = k;
                checks++;
                e = exp_q.pop_front();
                if ({s, r} !== e) begin
                    failures++;
                    $display("FAIL basic_value got r=%h s=%b want r=%h s=%b", r, s, e[16:0], e[17]);
                end
            end
        end
        checks++;
        if (acc_step != 0 || out_step - acc_step != 5) begin
            failures++;
            $display("FAIL basic_latency got acc=%0d out=%0d want latency 5", acc_step, out_step);
        end
    endtask

    task automatic test_edges();
        logic [16:0] tin  [6];
        logic        tf   [6];
        logic [4:0]  tc   [6];
        logic [17:0] texp [6];
        logic a, of, s;
        logic [16:0] r;
        logic [17:0] e;
        int idx = 0;
        int got = 0;
        tin  = '{17'h00001, 17'h1FFFF, 17'h0F0F0, 17'h0F0F0, 17'h0F0F0, 17'h00000};
        tf   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tc   = '{5'd1, 5'd16, 5'd20, 5'd20, 5'd0, 5'd20};
        texp = '{{1'b1, 17'h10000}, {1'b1, 17'h00001}, {1'b1, 17'h00000},
                 {1'b1, 17'h1FFFF}, {1'b0, 17'h0F0F0}, {1'b0, 17'h1FFFF}};
        for (int k = 0; k < 100 && got < 6; k++) begin
            tick(idx < 6, idx < 6 ? tin[idx] : 17'h0, idx < 6 ? tf[idx] : 1'b0,
                 idx < 6 ? tc[idx] : 5'd0, 1'b1, a, of, r, s);
            if (a) begin
                exp_q.push_back(texp[idx]);
                idx++;
            end
            if (of) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL edges_extra got r=%h s=%b want none", r, s);
                end else begin
                    e = exp_q.pop_front();
                    if ({s, r} !== e) begin
                        failures++;
                        $display("FAIL edges_item%0d got r=%h s=%b want r=%h s=%b",
                                 got - 1, r, s, e[16:0], e[17]);
                    end
                end
            end
        end
        checks++;
        if (got != 6) begin
            failures++; $display("FAIL edges_count got=%0d want=6", got);
        end
    endtask

    task automatic test_round_trip();
        logic a, of, s;
        logic [16:0] r, x;
        logic [4:0]  c;
        logic [17:0] e;
        int idx = 0;
        int got = 0;
        int steps = 0;
        x = rand_word();
        c = run_len(x);
        for (int k = 0; k < 1100 && got < 1000; k++) begin
            tick(idx < 1000, x << c, x[16], c, 1'b1, a, of, r, s);
            steps++;
            if (a) begin
                exp_q.push_back({1'b0, x});
                idx++;
                x = rand_word();
                c = run_len(x);
            end
            if (of) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL roundtrip_extra got r=%h s=%b want none", r, s);
                end else begin
                    e = exp_q.pop_front();
                    if ({s, r} !== e) begin
                        failures++;
                        $display("FAIL roundtrip got r=%h s=%b want r=%h s=0", r, s, e[16:0]);
                    end
                end
            end
        end
        checks++;
        if (got != 1000 || steps > 1010) begin
            failures++;
            $display("FAIL roundtrip_throughput got items=%0d steps=%0d want 1000 in <=1010", got, steps);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] bin [8];
        logic        bf  [8];
        logic [4:0]  bc  [8];
        logic a, of, s, rdy;
        logic [16:0] r;
        logic [17:0] e;
        int idx = 0;
        int got = 0;
        for (int i = 0; i < 8; i++) begin
            bin[i] = 17'($urandom);
            bf[i]  = 1'($urandom);
            bc[i]  = 5'($urandom_range(0, 31));
        end
        for (int k = 0; k < 100 && got < 8; k++) begin
            rdy = !(k >= 3 && k <= 9);
            tick(idx < 8, idx < 8 ? bin[idx] : 17'h0, idx < 8 ? bf[idx] : 1'b0,
                 idx < 8 ? bc[idx] : 5'd0, rdy, a, of, r, s);
            if (k == 4 || k == 5 || k == 9) begin
                checks++;
                if (a !== (k == 4)) begin
                    failures++;
                    $display("FAIL bp_o_ready step=%0d got=%b want=%b", k, a, k == 4);
                end
            end
            if (a) begin
                exp_q.push_back(model(bin[idx], bf[idx], bc[idx]));
                idx++;
            end
            if (of) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra got r=%h s=%b want none", r, s);
                end else begin
                    e = exp_q.pop_front();
                    if ({s, r} !== e) begin
                        failures++;
                        $display("FAIL bp_item%0d got r=%h s=%b want r=%h s=%b",
                                 got - 1, r, s, e[16:0], e[17]);
                    end
                end
            end
        end
        checks++;
        if (got != 8) begin
            failures++; $display("FAIL bp_count got=%0d want=8", got);
        end
    endtask

    task automatic test_mid_reset();
        logic a, of, s;
        logic [16:0] r;
        logic [17:0] e;
        int seen = 0;
        int acc_step = -1;
        int out_step = -1;
        for (int k = 0; k < 3; k++) tick(1'b1, 17'($urandom), 1'b0, 5'd2, 1'b1, a, of, r, s);
        @(negedge clk);
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_in    = 17'h12345;
        bus.i_count = 5'd4;
        @(negedge clk);
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_r !== 17'h0 || bus.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state got v=%b r=%h rdy=%b want v=0 r=00000 rdy=1",
                     bus.o_valid, bus.o_r, bus.o_ready);
        end
        exp_q.delete();
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 17'h0, 1'b0, 5'd0, 1'b1, a, of, r, s);
            if (of) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL midreset_leak got=%0d outputs want=0", seen);
        end
        for (int k = 0; k < 20 && out_step < 0; k++) begin
            tick(k == 0, 17'h0AAAA, 1'b1, 5'd5, 1'b1, a, of, r, s);
            if (a) begin
                acc_step = k;
                exp_q.push_back(model(17'h0AAAA, 1'b1, 5'd5));
            end
            if (of) begin
                out_step = k;
                checks++;
                e = exp_q.pop_front();
                if ({s, r} !== e) begin
                    failures++;
                    $display("FAIL midreset_value got r=%h s=%b want r=%h s=%b", r, s, e[16:0], e[17]);
                end
            end
        end
        checks++;
        if (acc_step != 0 || out_step - acc_step != 5) begin
            failures++;
            $display("FAIL midreset_latency got acc=%0d out=%0d want latency 5", acc_step, out_step);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_round_trip();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
